// File: rtl/regfile_pkg.sv
// Shared constants and address helpers for the MMIO register file:
// default window placement, named peripheral registers, window membership.
package regfile_pkg;

    localparam int DEF_OUT_BASE    = 18;
    localparam int DEF_N_OUT       = 5;
    localparam int DEF_IN_BASE     = 26;
    localparam int DEF_N_IN        = 3;
    localparam int DEF_STATUS_ADDR = 29;

    // Peripheral registers exported through the output window
    localparam int ADDR_SERVO        = 18;
    localparam int ADDR_STEP_X_DIR   = 19;
    localparam int ADDR_STEP_Y_DIR   = 20;
    localparam int ADDR_STEP_X_SPEED = 21;
    localparam int ADDR_STEP_Y_SPEED = 22;

    function automatic bit in_window(int addr, int base, int size);
        return (addr >= base) && (addr < base + size);
    endfunction

    // Address 0, the input window and the status register never hold written data
    function automatic bit is_writable(int addr, int in_base, int n_in, int status_addr);
        return (addr != 0) && !in_window(addr, in_base, n_in) && (addr != status_addr);
    endfunction

endpackage

// File: rtl/regfile_mmio_if.sv
// Processor-side register-file bus: one write port and N_RD packed read ports.
interface regfile_mmio_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
);
    logic                   ctrl_writeEnable;
    logic [ADDR_W-1:0]      ctrl_writeReg;
    logic [DATA_W-1:0]      data_writeReg;
    logic [N_RD*ADDR_W-1:0] ctrl_readReg;
    logic [N_RD*DATA_W-1:0] data_readReg;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
        input  data_readReg
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
        output data_readReg
    );
endinterface

// File: rtl/regfile_mmio_sync2.sv
// Two-flop synchroniser for a quasi-static multi-bit external source.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] s1;

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/regfile_mmio.sv
// Parametrised register file with write bypass, an exported output window with
// update strobes, a synchronised read-only input window and a sticky W1C status.
module regfile_mmio
    import regfile_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int N_RD        = 2,
    parameter int OUT_BASE    = DEF_OUT_BASE,
    parameter int N_OUT       = DEF_N_OUT,
    parameter int IN_BASE     = DEF_IN_BASE,
    parameter int N_IN        = DEF_N_IN,
    parameter int STATUS_ADDR = DEF_STATUS_ADDR,
    parameter bit BYPASS      = 1'b1
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    regfile_mmio_if.slave           bus,
    output logic [N_OUT*DATA_W-1:0] out_regs,
    output logic [N_OUT-1:0]        out_update,
    input  logic [N_IN*DATA_W-1:0]  in_regs
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam bit OUT_OK  = (OUT_BASE > 0) && (N_OUT > 0) && (OUT_BASE + N_OUT <= DEPTH);
    localparam bit IN_OK   = (IN_BASE > 0) && (N_IN > 0) && (IN_BASE + N_IN <= DEPTH);
    localparam bit STAT_OK = (STATUS_ADDR > 0) && (STATUS_ADDR < DEPTH);
    localparam bit DISJ_OK = ((OUT_BASE + N_OUT <= IN_BASE) || (IN_BASE + N_IN <= OUT_BASE))
                             && !in_window(STATUS_ADDR, OUT_BASE, N_OUT)
                             && !in_window(STATUS_ADDR, IN_BASE, N_IN);
    localparam bit W_OK    = (N_IN <= DATA_W);

    if (!(OUT_OK && IN_OK && STAT_OK && DISJ_OK && W_OK)) begin : g_param_check
        $error("regfile_mmio: illegal window/status parameters");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] s2 [N_IN];
    logic [DATA_W-1:0] s3 [N_IN];
    logic [N_IN-1:0]   status;
    logic [N_IN-1:0]   change;
    logic [N_IN-1:0]   clear;
    logic [N_OUT-1:0]  out_hit;
    logic [ADDR_W-1:0] wa;
    logic              wr_store;
    logic              wr_status;
    logic [N_RD*DATA_W-1:0] rd_data;

    assign wa = bus.ctrl_writeReg;

    // Writes are dead while reset is held, so nothing is stored or forwarded then
    assign wr_store  = bus.ctrl_writeEnable && ctrl_reset
                       && is_writable(int'(wa), IN_BASE, N_IN, STATUS_ADDR);
    assign wr_status = bus.ctrl_writeEnable && ctrl_reset && (int'(wa) == STATUS_ADDR);

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
        end else if (wr_store) begin
            mem[wa] <= bus.data_writeReg;
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        assign out_regs[i*DATA_W +: DATA_W] = mem[OUT_BASE + i];
    end

    always_comb begin
        out_hit = '0;
        for (int i = 0; i < N_OUT; i++) begin
            out_hit[i] = wr_store && (int'(wa) == OUT_BASE + i);
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) out_update <= '0;
        else             out_update <= out_hit;
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        sync2 #(.WIDTH(DATA_W)) u_sync (
            .clock      (clock),
            .ctrl_reset (ctrl_reset),
            .d          (in_regs[i*DATA_W +: DATA_W]),
            .q          (s2[i])
        );
    end

    // s3 lags the visible value by one edge; a difference marks a fresh change
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < N_IN; i++) s3[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) s3[i] <= s2[i];
        end
    end

    always_comb begin
        change = '0;
        for (int i = 0; i < N_IN; i++) change[i] = (s2[i] != s3[i]);
        clear = wr_status ? bus.data_writeReg[N_IN-1:0] : '0;
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) status <= '0;
        else             status <= (status & ~clear) | change;
    end

    always_comb begin : read_mux
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        rd_data = '0;
        for (int p = 0; p < N_RD; p++) begin
            ra = bus.ctrl_readReg[p*ADDR_W +: ADDR_W];
            if (int'(ra) == STATUS_ADDR) begin
                rd_data[p*DATA_W +: N_IN] = status;
            end else if (in_window(int'(ra), IN_BASE, N_IN)) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (int'(ra) == IN_BASE + i) rd_data[p*DATA_W +: DATA_W] = s2[i];
                end
            end else if (BYPASS && wr_store && (ra == wa)) begin
                rd_data[p*DATA_W +: DATA_W] = bus.data_writeReg;
            end else if (ra != '0) begin
                rd_data[p*DATA_W +: DATA_W] = mem[ra];
            end
        end
    end

    assign bus.data_readReg = rd_data;

endmodule

// File: tb/tb_regfile_mmio.sv
// Bench for regfile_mmio: directed checks on default-sized instances (with and
// without bypass) and a randomised scoreboard on a 16-bit, 64-entry, 3-port build.
module tb_regfile_mmio;
    import regfile_pkg::*;

    logic clock = 1'b0;
    logic ctrl_reset;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mmio_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) bus_a ();
    regfile_mmio_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) bus_c ();
    regfile_mmio_if #(.DATA_W(16), .ADDR_W(6), .N_RD(3)) bus_b ();

    logic [5*32-1:0] out_regs_a, out_regs_c;
    logic [4:0]      out_update_a, out_update_c, out_update_b;
    logic [3*32-1:0] in_regs_a, in_regs_c;
    logic [5*16-1:0] out_regs_b;
    logic [3*16-1:0] in_regs_b;

    regfile_mmio dut_a (
        .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus_a),
        .out_regs(out_regs_a), .out_update(out_update_a), .in_regs(in_regs_a)
    );

    regfile_mmio #(.BYPASS(1'b0)) dut_c (
        .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus_c),
        .out_regs(out_regs_c), .out_update(out_update_c), .in_regs(in_regs_c)
    );

    regfile_mmio #(.DATA_W(16), .ADDR_W(6), .N_RD(3)) dut_b (
        .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus_b),
        .out_regs(out_regs_b), .out_update(out_update_b), .in_regs(in_regs_b)
    );

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_a(logic we, logic [4:0] a, logic [31:0] d);
        bus_a.ctrl_writeEnable = we;
        bus_a.ctrl_writeReg    = a;
        bus_a.data_writeReg    = d;
    endtask

    task automatic wr_c(logic we, logic [4:0] a, logic [31:0] d);
        bus_c.ctrl_writeEnable = we;
        bus_c.ctrl_writeReg    = a;
        bus_c.data_writeReg    = d;
    endtask

    function automatic logic [31:0] rd_a(int p);
        return bus_a.data_readReg[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rd_c(int p);
        return bus_c.data_readReg[p*32 +: 32];
    endfunction

    // Reference model for dut_b: plain storage, a history of sampled inputs
    // (newest first) and the sticky status bits.
    logic [15:0] m_mem [64];
    logic [47:0] samp [$];
    logic [2:0]  m_stat;
    logic [4:0]  m_upd;

    function automatic logic [15:0] exp_read_b(int a, logic we, int wa, logic [15:0] wd);
        logic [47:0] seen;
        if (a == 0) return 16'h0;
        if (a >= DEF_IN_BASE && a < DEF_IN_BASE + DEF_N_IN) begin
            seen = samp[1];
            return 16'(seen >> ((a - DEF_IN_BASE) * 16));
        end
        if (a == DEF_STATUS_ADDR) return {13'b0, m_stat};
        if (we && wa == a) return wd;
        return m_mem[a];
    endfunction

    logic        r_we;
    int          r_wa;
    logic [15:0] r_wd;
    int          r_ra [3];
    int          held;
    int          slot;
    logic [2:0]  m_set, m_clr;
    logic [47:0] cur, prev;

    initial begin
        ctrl_reset = 1'b0;
        wr_a(0, 0, 0); wr_c(0, 0, 0);
        bus_a.ctrl_readReg = '0; bus_c.ctrl_readReg = '0;
        bus_b.ctrl_writeEnable = 1'b0; bus_b.ctrl_writeReg = '0;
        bus_b.data_writeReg = '0; bus_b.ctrl_readReg = '0;
        in_regs_a = '0; in_regs_c = '0; in_regs_b = '0;
        repeat (3) @(posedge clock);
        #1 ctrl_reset = 1'b1;

        // Populate, then drop reset in the middle of a write
        wr_a(1, 5, 32'h77); tick();
        wr_a(1, 21, 32'h55); tick();
        check_eq("pre_rst_upd", out_update_a, 5'b01000);
        bus_a.ctrl_readReg = {5'd21, 5'd5}; #1;
        check_eq("pre_rst_r5", rd_a(0), 32'h77);
        check_eq("pre_rst_byp", rd_a(1), 32'h55);
        #1 ctrl_reset = 1'b0; #1;
        check_eq("rst_upd", out_update_a, 5'b0);
        check_eq("rst_r5", rd_a(0), 32'h0);
        check_eq("rst_byp", rd_a(1), 32'h0);
        for (int i = 0; i < 5; i++) check_eq("rst_out_regs", out_regs_a[i*32 +: 32], 32'h0);
        @(posedge clock); #1;
        ctrl_reset = 1'b1; wr_a(0, 0, 0);

        // Register 0
        wr_a(1, 0, 32'hDEADBEEF); bus_a.ctrl_readReg = {5'd0, 5'd0}; #1;
        check_eq("r0_same_cycle", rd_a(0), 32'h0);
        tick(); wr_a(0, 0, 0); #1;
        check_eq("r0_after", rd_a(1), 32'h0);

        // Bypass vs stored value
        wr_a(1, 5, 32'hA); wr_c(1, 5, 32'hA); tick();
        wr_a(1, 5, 32'h12345678); wr_c(1, 5, 32'h12345678);
        bus_a.ctrl_readReg = {5'd5, 5'd5}; bus_c.ctrl_readReg = {5'd5, 5'd5}; #1;
        check_eq("byp1_p0", rd_a(0), 32'h12345678);
        check_eq("byp1_p1", rd_a(1), 32'h12345678);
        check_eq("byp0_p0", rd_c(0), 32'hA);
        check_eq("byp0_p1", rd_c(1), 32'hA);
        tick(); wr_a(0, 0, 0); wr_c(0, 0, 0); #1;
        check_eq("byp0_after_p0", rd_c(0), 32'h12345678);
        check_eq("byp0_after_p1", rd_c(1), 32'h12345678);
        check_eq("byp1_after", rd_a(1), 32'h12345678);

        // Output window and update strobes
        wr_a(1, 5'(ADDR_STEP_X_SPEED), 32'h40); tick(); wr_a(0, 0, 0);
        check_eq("out_slot3", out_regs_a[3*32 +: 32], 32'h40);
        check_eq("upd_once", out_update_a, 5'b01000);
        tick();
        check_eq("upd_drop", out_update_a, 5'b0);
        wr_a(1, 5'(ADDR_SERVO), 32'h99); tick();
        check_eq("upd_b2b_1", out_update_a, 5'b00001);
        tick(); wr_a(0, 0, 0);
        check_eq("upd_b2b_2", out_update_a, 5'b00001);
        check_eq("out_slot0", out_regs_a[0 +: 32], 32'h99);
        tick();
        check_eq("upd_b2b_end", out_update_a, 5'b0);

        // Input window synchronisation and status
        in_regs_a[32 +: 32] = 32'h7;
        bus_a.ctrl_readReg = {5'd29, 5'd27};
        tick();
        check_eq("in_1edge", rd_a(0), 32'h0);
        tick();
        check_eq("in_2edge", rd_a(0), 32'h7);
        check_eq("stat_2edge", rd_a(1), 32'h0);
        tick();
        check_eq("stat_3edge", rd_a(1), 32'h2);
        wr_a(1, 27, 32'h2); #1;
        check_eq("in_ro_same", rd_a(0), 32'h7);
        tick(); wr_a(0, 0, 0); #1;
        check_eq("in_ro_after", rd_a(0), 32'h7);
        check_eq("stat_sticky", rd_a(1), 32'h2);

        // Write-1-to-clear; status is never bypassed
        wr_a(1, 29, 32'h2); #1;
        check_eq("stat_nobyp", rd_a(1), 32'h2);
        tick(); wr_a(0, 0, 0); #1;
        check_eq("stat_w1c", rd_a(1), 32'h0);

        // Clear on the same edge as a new change: set wins
        in_regs_a[32 +: 32] = 32'h3;
        tick(); tick();
        wr_a(1, 29, 32'h2); tick(); wr_a(0, 0, 0); #1;
        check_eq("stat_set_wins", rd_a(1), 32'h2);
        tick();
        check_eq("stat_hold", rd_a(1), 32'h2);
        wr_a(1, 29, 32'hFFFFFFFF); tick(); wr_a(0, 0, 0); #1;
        check_eq("stat_clr_all", rd_a(1), 32'h0);

        // Randomised scoreboard on the 16-bit / 64-entry / 3-port build
        for (int a = 0; a < 64; a++) m_mem[a] = '0;
        samp   = '{48'h0, 48'h0, 48'h0};
        m_stat = '0;
        m_upd  = '0;
        held   = 0;
        for (int c = 0; c < 10000; c++) begin
            r_we = ($urandom_range(0, 2) != 0);
            r_wa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(16, 31))
                                               : int'($urandom_range(0, 63));
            r_wd = 16'($urandom);
            bus_b.ctrl_writeEnable = r_we;
            bus_b.ctrl_writeReg    = 6'(r_wa);
            bus_b.data_writeReg    = r_wd;
            for (int p = 0; p < 3; p++) begin
                r_ra[p] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(16, 31))
                                                      : int'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) r_ra[p] = r_wa;
                bus_b.ctrl_readReg[p*6 +: 6] = 6'(r_ra[p]);
            end
            if (held >= 4 && $urandom_range(0, 7) == 0) begin
                slot = int'($urandom_range(0, 2));
                in_regs_b[slot*16 +: 16] = 16'($urandom);
                held = 0;
            end else begin
                held++;
            end
            #1;
            for (int p = 0; p < 3; p++) begin
                check_eq($sformatf("rnd_rd%0d_a%0d", p, r_ra[p]),
                         bus_b.data_readReg[p*16 +: 16],
                         exp_read_b(r_ra[p], r_we, r_wa, r_wd));
            end
            for (int i = 0; i < 5; i++) check_eq("rnd_out_regs", out_regs_b[i*16 +: 16], m_mem[18 + i]);
            check_eq("rnd_out_update", out_update_b, m_upd);

            @(posedge clock);
            cur  = samp[1];
            prev = samp[2];
            m_set = '0;
            for (int i = 0; i < 3; i++) begin
                if (16'(cur >> (i * 16)) != 16'(prev >> (i * 16))) m_set = m_set | 3'(1 << i);
            end
            m_clr  = (r_we && r_wa == DEF_STATUS_ADDR) ? r_wd[2:0] : 3'b0;
            m_stat = (m_stat & ~m_clr) | m_set;
            m_upd  = '0;
            if (r_we && r_wa != 0 && r_wa != DEF_STATUS_ADDR
                && !(r_wa >= DEF_IN_BASE && r_wa < DEF_IN_BASE + DEF_N_IN)) begin
                m_mem[r_wa] = r_wd;
                if (r_wa >= DEF_OUT_BASE && r_wa < DEF_OUT_BASE + DEF_N_OUT)
                    m_upd = 5'(1 << (r_wa - DEF_OUT_BASE));
            end
            samp.push_front(in_regs_b);
            void'(samp.pop_back());
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mmio.md
# regfile_mmio

Parametrised register file with memory-mapped I/O windows, replacing the fixed 32×32 two-read-port register file in the processor. It provides N_RD combinational read ports, one write port, and optional write-to-read bypass. It also has an output window of registers exported to peripherals (stepper direction/speed, servo duty) with per-register update strobes, and an input window of read-only registers fed by synchronised external sources (shape selectors). A sticky change-status register lets software poll the input window.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports
- OUT_BASE, 18, first address of output window
- N_OUT, 5, output window size
- IN_BASE, 26, first address of input window
- N_IN, 3, input window size
- STATUS_ADDR, 29, sticky change-status register address
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
- clock  in  1  sole clock, rising edge
- ctrl_reset  in  1  asynchronous, active-low reset
- ctrl_writeEnable  in  1  write strobe
- ctrl_writeReg  in  ADDR_W  write address
- data_writeReg  in  DATA_W  write data
- ctrl_readReg  in  N_RD*ADDR_W  read addresses; port p at [p*ADDR_W +: ADDR_W]
- data_readReg  out  N_RD*DATA_W  read data; port p at [p*DATA_W +: DATA_W]
- out_regs  out  N_OUT*DATA_W  output-window contents; slot i = address OUT_BASE+i
- out_update  out  N_OUT  one-cycle pulse per output slot after it is written
- in_regs  in  N_IN*DATA_W  external, asynchronous, quasi-static sources (held ≥3 cycles)

## Operation
- Address 0: reads 0; writes ignored.
- General and output-window addresses: written at the rising edge when ctrl_writeEnable=1.
- Input window (IN_BASE..IN_BASE+N_IN-1):
  - Read-only; writes are ignored.
  - Each slot is sampled through a 2-flop synchroniser (s1, s2). Reads return s2.
  - A third stage s3 follows s2.
- Status register:
  - Bit i sets when s2[i] != s3[i] (any bit differs). Bits N_IN and above read 0.
  - Writing STATUS_ADDR clears bit i wherever data_writeReg[i]=1 (write-1-to-clear).
  - Set wins over a simultaneous clear.
  - The status register holds no general storage.
- Read ports:
  - Combinational and independent; all N_RD ports may address the same register.
  - BYPASS=1: if ctrl_writeEnable and ctrl_writeReg equals the read address, and that address is a writable general or output register, the read returns data_writeReg.
  - BYPASS=0: the read returns the stored value.
  - Bypass never applies to address 0, the input window or STATUS_ADDR.
- out_update[i]: registered. High for exactly one cycle after every edge that writes OUT_BASE+i, including writes of an unchanged value.
- Parameter legality:
  - Output window, input window and STATUS_ADDR are disjoint, exclude 0, and lie below 2**ADDR_W.
  - N_IN ≤ DATA_W.
  - A violation is an elaboration-time error.

## Timing
- Reset (asynchronous assert, while low):
  - All storage, s1/s2/s3, status bits and out_update are 0.
  - data_readReg and out_regs therefore read 0.
  - Reset mid-operation aborts any pending update pulse.
- Write at edge k: stored value is visible from k onward; out_regs changes at k; out_update pulses during cycle k..k+1.
- Bypass: read equals data_writeReg in the same cycle as the write, before edge k.
- Input change captured at edge t:
  - s2, and therefore the read value, updates at edge t+1.
  - Status bit sets at edge t+2.
- Inputs nonzero at reset release set their status bits once after synchronisation; this is intended.
- Back-to-back writes to the same output slot hold out_update high continuously, one pulse-cycle per write.

## Structure
- Shared package regfile_pkg:
  - Default window constants (OUT_BASE/N_OUT/IN_BASE/N_IN/STATUS_ADDR).
  - Named addresses for servo (18), step_x_dir (19), step_y_dir (20), step_x_speed (21), step_y_speed (22).
  - Window-membership helper functions.
- One sub-module: sync2, a parametric-width 2-flop synchroniser with asynchronous active-low reset, instantiated once per input slot.
- Storage, bypass muxes, status logic and strobes stay in regfile_mmio.

## Test plan
- Reset and reg 0:
  - Assert ctrl_reset low mid-write → all reads, out_regs and out_update are 0 immediately.
  - Write 0xDEADBEEF to address 0 → reads 0.
- Bypass:
  - BYPASS=1: write 0x12345678 to r5 while port0 and port1 read r5 → both return 0x12345678 in the same cycle.
  - BYPASS=0 (r5 previously 0xA) → both return 0xA, then 0x12345678 after the edge.
- Output window:
  - Write 0x40 to r21 → out_regs slot 3 = 0x40 and out_update = 5'b01000 for one cycle.
  - Two consecutive writes → pulse stays high for 2 cycles.
- Input window:
  - Set in_regs slot 1 = 0x7 → read r27 returns 0x7 after 2 edges; status reads 0x2 after 3 edges.
  - Write 0x2 to r27 → no effect.
- Status W1C:
  - Write 0x2 to STATUS_ADDR → status reads 0.
  - Clear coinciding with a new change on slot 1 → bit stays set.
- Parameter sweep:
  - DATA_W=16, ADDR_W=6, N_RD=3 → random write/read scoreboard of 10k cycles matches the reference model.
